// File: rtl/jt12_acc_mix.sv
// Channel accumulator and stereo mixer for a 4-operator FM core. Per-channel
// partial sums ride a NUM_CH-deep ring; finished sums are panned into the mix.
`timescale 1ns/1ps
module jt12_acc_mix #(
  parameter int NUM_CH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [8:0]  op_result,
  input  logic        s1_enters,
  input  logic        s2_enters,
  input  logic        s3_enters,
  input  logic        s4_enters,
  input  logic [2:0]  alg,
  input  logic [1:0]  pan_rl,
  input  logic        zero,
  output logic [11:0] ch_out,
  output logic        ch_valid,
  output logic [15:0] snd_left,
  output logic [15:0] snd_right,
  output logic        sample
);

  typedef enum logic [2:0] {SLOT_NONE, SLOT_S1, SLOT_S2, SLOT_S3, SLOT_S4} slot_e;

  slot_e       slot;
  logic        carrier;
  logic        is_s4;
  logic [11:0] term, shift_out, ch_sum;
  logic [11:0] sr_q [NUM_CH];
  logic [11:0] sr_d [NUM_CH];
  logic [11:0] ch_out_q, ch_out_d;
  logic        ch_valid_q, ch_valid_d;
  logic [15:0] mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  logic [15:0] snd_left_q, snd_left_d, snd_right_q, snd_right_d;
  logic        sample_q, sample_d;
  logic [15:0] add_l, add_r, mix_l_sum, mix_r_sum;

  // Overlapping tags resolve S1 > S3 > S2 > S4.
  always_comb begin
    if (s1_enters)      slot = SLOT_S1;
    else if (s3_enters) slot = SLOT_S3;
    else if (s2_enters) slot = SLOT_S2;
    else if (s4_enters) slot = SLOT_S4;
    else                slot = SLOT_NONE;
  end

  always_comb begin
    case (alg)
      3'd0, 3'd1, 3'd2, 3'd3: carrier = (slot == SLOT_S4);
      3'd4:                   carrier = (slot == SLOT_S2) || (slot == SLOT_S4);
      3'd5, 3'd6:             carrier = (slot == SLOT_S2) || (slot == SLOT_S3) || (slot == SLOT_S4);
      default:                carrier = (slot != SLOT_NONE);
    endcase
  end

  assign term      = carrier ? {{3{op_result[8]}}, op_result} : '0;
  assign shift_out = sr_q[NUM_CH-1];
  assign ch_sum    = shift_out + term;
  assign is_s4     = (slot == SLOT_S4);

  always_comb begin
    for (int unsigned i = 1; i < NUM_CH; i++) sr_d[i] = sr_q[i-1];
    sr_d[0] = shift_out;
    case (slot)
      SLOT_S1:          sr_d[0] = term;
      SLOT_S2, SLOT_S3: sr_d[0] = ch_sum;
      SLOT_S4:          sr_d[0] = '0;
      default:          sr_d[0] = shift_out;
    endcase
  end

  // Outside an S4 slot the pan adds are zero, so a zero strobe there just
  // publishes the accumulators as they stand.
  always_comb begin
    ch_valid_d  = is_s4;
    ch_out_d    = is_s4 ? ch_sum : ch_out_q;
    add_l       = (is_s4 && pan_rl[1]) ? {{4{ch_sum[11]}}, ch_sum} : '0;
    add_r       = (is_s4 && pan_rl[0]) ? {{4{ch_sum[11]}}, ch_sum} : '0;
    mix_l_sum   = mix_l_q + add_l;
    mix_r_sum   = mix_r_q + add_r;
    snd_left_d  = snd_left_q;
    snd_right_d = snd_right_q;
    mix_l_d     = mix_l_sum;
    mix_r_d     = mix_r_sum;
    sample_d    = 1'b0;
    if (zero) begin
      snd_left_d  = mix_l_sum;
      snd_right_d = mix_r_sum;
      mix_l_d     = '0;
      mix_r_d     = '0;
      sample_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) sr_q[i] <= '0;
      ch_out_q    <= '0;
      ch_valid_q  <= 1'b0;
      mix_l_q     <= '0;
      mix_r_q     <= '0;
      snd_left_q  <= '0;
      snd_right_q <= '0;
      sample_q    <= 1'b0;
    end else if (clk_en) begin
      for (int unsigned i = 0; i < NUM_CH; i++) sr_q[i] <= sr_d[i];
      ch_out_q    <= ch_out_d;
      ch_valid_q  <= ch_valid_d;
      mix_l_q     <= mix_l_d;
      mix_r_q     <= mix_r_d;
      snd_left_q  <= snd_left_d;
      snd_right_q <= snd_right_d;
      sample_q    <= sample_d;
    end
  end

  assign ch_out    = ch_out_q;
  assign ch_valid  = ch_valid_q;
  assign snd_left  = snd_left_q;
  assign snd_right = snd_right_q;
  assign sample    = sample_q;

endmodule

// File: doc/jt12_acc_mix.md
JT12_ACC_MIX -- requirements
Module: jt12_acc_mix

Interface
REQ-001 Parameter NUM_CH, default 6: number of channels interleaved per operator slot group; sets the accumulator shift depth.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 clk_en  input  1  clock enable; state advances only on clk edges with clk_en=1.
REQ-005 op_result  input  9  signed operator output for the current slot.
REQ-006 s1_enters, s2_enters, s3_enters, s4_enters  input  1 each  one-hot slot group tag for op_result this cycle.
REQ-007 alg  input  3  algorithm of the channel in the current slot, slot-aligned with op_result.
REQ-008 pan_rl  input  2  [1]=left enable, [0]=right enable of current channel; sampled only in S4 slots.
REQ-009 zero  input  1  high in the S4 slot of the last channel of a sample period.
REQ-010 ch_out  output  12  signed per-channel sum, registered.
REQ-011 ch_valid  output  1  high for one enabled cycle when ch_out is new.
REQ-012 snd_left, snd_right  output  16 each  signed mixed sample, registered.
REQ-013 sample  output  1  high for one enabled cycle when snd_left/snd_right update.

Function
REQ-014 Carrier decode: alg 0-3 -> S4 only; alg 4 -> S2, S4; alg 5-6 -> S2, S3, S4; alg 7 -> S1, S2, S3, S4.
REQ-015 Term: op_result sign-extended to 12 bits when current slot is a carrier for alg, else 0.
REQ-016 Per-channel partial sums held in a NUM_CH-deep, 12-bit shift register advancing every enabled cycle.
REQ-017 S1 slot: shift-in value = term (previous contents discarded).
REQ-018 S3 or S2 slot: shift-in value = shifted-out value + term.
REQ-019 S4 slot: shift-in value = 0; channel sum = shifted-out value + term.
REQ-020 Channel sum registered to ch_out with ch_valid=1 on the edge ending the S4 slot; latency one enabled cycle.
REQ-021 ch_valid=0 on every enabled cycle that does not end an S4 slot; ch_out holds its last value.
REQ-022 Arithmetic: 12-bit two's complement; max magnitude 4x256=1024, no saturation needed or applied.
REQ-023 No s*_enters asserted: shift-in = shifted-out value unchanged, no term added, ch_valid=0.
REQ-024 More than one s*_enters asserted: priority S1 > S3 > S2 > S4.
REQ-025 Mixer: 16-bit signed accumulators mix_l, mix_r; in each S4 slot add sign-extended channel sum to mix_l if pan_rl[1], to mix_r if pan_rl[0].
REQ-026 zero in an S4 slot: snd_left <= mix_l + same-cycle left contribution, snd_right likewise; mix_l, mix_r <= 0; sample=1 next cycle.
REQ-027 zero outside an S4 slot: snd outputs updated from mix accumulators only (no term); accumulators cleared; sample=1.
REQ-028 sample=0 on all other enabled cycles; snd outputs hold between updates.
REQ-029 Mixer wraps modulo 2^16 (6x1024 cannot overflow; no saturation logic).
REQ-030 clk_en=0: all registers, shift stages and one-cycle strobes hold; strobes last exactly one enabled cycle.

Reset
REQ-031 rst=1 asynchronously clears all shift stages, mix_l, mix_r, ch_out, snd_left, snd_right to 0 and ch_valid, sample to 0.
REQ-032 Reset mid-sample: partial sums discarded; first sample after release reflects only slots after release.
REQ-033 After release, first enabled edge operates normally; no warm-up cycles.

Verification
REQ-034 alg=7, all four slots of channel 0 op_result=+100 -> ch_out=400, ch_valid one cycle after its S4 slot.
REQ-035 alg=0, S1/S3/S2 =+255, S4=-3 -> ch_out=-3 (modulators excluded).
REQ-036 alg=4, S2=-256, S4=-256 -> ch_out=-512; pan_rl=2'b10 -> only snd_left gets -512 at next zero.
REQ-037 All 6 channels alg=7, every op=+255, pan_rl=2'b11, zero on last S4 -> snd_left=snd_right=6120, sample pulses once, mixers restart at 0.
REQ-038 clk_en toggled 1/0 throughout a REQ-034 stream -> results identical to clk_en=1, strobes one enabled cycle each.
REQ-039 rst pulsed mid-sample after 10 slots -> all outputs 0 immediately; next sample excludes pre-reset slots.
